// File: rtl/mux_4_1_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the 4-requester round-robin
// arbiter that drives the select lines of a 4:1 single-bit mux.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Binary index of a one-hot vector; returns 0 for an all-zero input.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] onehot);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (onehot[k]) idx = idx | SEL_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_4_1_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux_4_1_arbiter_if;
  import mux_arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (
    output en,
    output req,
    input  gnt,
    input  sel,
    input  busy
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output sel,
    output busy
  );

endinterface

// File: rtl/mux_4_1_arbiter_rr_pick4.sv
// Combinational round-robin picker: scans upward from last+1 with wrap-around
// and returns the first requester that is both requesting and unmasked.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  input  logic [N_REQ-1:0] mask,
  output logic [SEL_W-1:0] winner_idx,
  output logic             found
);

  logic [N_REQ-1:0] eligible;

  assign eligible = req & mask;

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise paths that skip the assignment infer latches.
  always_comb begin
    logic [SEL_W-1:0] idx;
    found      = 1'b0;
    winner_idx = '0;
    idx        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        winner_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_arbiter.sv
// Round-robin arbiter with a bounded hold time; registers a one-hot grant and
// the matching 4:1 mux select so there is no combinational req->gnt path.
module mux_4_1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_4_1_arbiter_if.slave    bus
);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  hold_q, hold_d;

  logic [SEL_W-1:0]  winner_idx;
  logic              found;
  logic              owner_req;
  logic              others_pending;
  logic              hold_full;

  // Masking with ~gnt excludes the owner during expiry rotation; in IDLE gnt
  // is zero so the same picker performs a fresh arbitration.
  rr_pick4 u_pick (
    .req        (bus.req),
    .last       (last_q),
    .mask       (~gnt_q),
    .winner_idx (winner_idx),
    .found      (found)
  );

  assign owner_req      = |(bus.req & gnt_q);
  assign others_pending = |(bus.req & ~gnt_q);
  assign hold_full      = (hold_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.en && found) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(1) << winner_idx;
          sel_d   = winner_idx;
          last_d  = winner_idx;
          hold_d  = CNT_W'(1);
        end
      end

      GRANT: begin
        if (!owner_req || (others_pending && hold_full)) begin
          // Release or expiry: hand off back-to-back when allowed, else go idle.
          if (bus.en && found) begin
            gnt_d  = N_REQ'(1) << winner_idx;
            sel_d  = winner_idx;
            last_d = winner_idx;
            hold_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (!hold_full) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Scoreboard bench: a behavioural owner/hold model predicts each registered
// grant; a monitor compares DUT outputs and the downstream mux output.
module tb_mux_4_1_arbiter;

  localparam int MAX_HOLD = 2;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       mux;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_4_1_arbiter_if bus ();

  mux_4_1_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Mux data inputs i_0..i_3 = 1,0,1,0 and the mux the arbiter steers.
  logic [3:0] mux_data = 4'b0101;
  logic       mux_out;
  assign mux_out = mux_data[bus.sel];

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model: owner (-1 = none), cycles held, last winner, select value.
  int         m_owner;
  int         m_held;
  int         m_last;
  logic [1:0] m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] cand);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_sel   = 2'd0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = 2'(w);
    m_held  = 1;
  endtask

  task automatic model_step(input logic e, input logic [3:0] r);
    logic [3:0] others;
    if (m_owner < 0) begin
      if (e && r != 4'b0) model_grant(rr_pick(m_last, r));
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (e && others != 4'b0) model_grant(rr_pick(m_last, others));
        else m_owner = -1;
      end else if (others != 4'b0) begin
        if (m_held >= MAX_HOLD) begin
          if (e) model_grant(rr_pick(m_last, others));
          else m_owner = -1;
        end else begin
          m_held++;
        end
      end else if (m_held < MAX_HOLD) begin
        m_held++;
      end
    end
  endtask

  function automatic exp_t model_expect();
    exp_t x;
    x.gnt  = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
    x.sel  = m_sel;
    x.busy = (m_owner >= 0);
    x.mux  = mux_data[m_sel];
    return x;
  endfunction

  // One arbitration cycle: drive at negedge, predict the next edge's outputs.
  task automatic cycle(input logic e, input logic [3:0] r);
    @(negedge clk);
    bus.en  = e;
    bus.req = r;
    model_step(e, r);
    exp_q.push_back(model_expect());
  endtask

  task automatic cycles(input int n, input logic e, input logic [3:0] r);
    for (int i = 0; i < n; i++) cycle(e, r);
  endtask

  // Monitor: pops one expectation per edge that has one pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", 32'(bus.gnt), 32'(e.gnt));
        check("sel", 32'(bus.sel), 32'(e.sel));
        check("busy", 32'(bus.busy), 32'(e.busy));
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        if (e.busy) check("mux_out", 32'(mux_out), 32'(e.mux));
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       e;
    bus.en  = 1'b0;
    bus.req = 4'b0;
    model_reset();

    #2;
    check("reset_gnt", 32'(bus.gnt), 32'h0);
    check("reset_sel", 32'(bus.sel), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness with everyone requesting.
    cycles(10, 1'b1, 4'b1111);
    cycles(2, 1'b1, 4'b0000);

    // Back-to-back handoff when the owner drops its request.
    cycles(3, 1'b1, 4'b0101);
    cycles(3, 1'b1, 4'b0100);
    cycles(3, 1'b1, 4'b0101);
    cycles(3, 1'b1, 4'b0001);
    cycles(2, 1'b1, 4'b0000);

    // Single requester: held indefinitely, then rotates at once when a
    // competitor shows up because the hold count is already saturated.
    cycles(20, 1'b1, 4'b0100);
    cycles(4, 1'b1, 4'b0110);
    cycles(3, 1'b1, 4'b0000);

    // Enable gating.
    cycles(3, 1'b0, 4'b1000);
    cycles(1, 1'b1, 4'b1000);
    cycles(5, 1'b0, 4'b1010);
    cycles(3, 1'b0, 4'b0010);

    // Async reset between edges while requester 1 owns the grant.
    cycles(2, 1'b1, 4'b0010);
    @(posedge clk);
    #3;
    check("pre_reset_gnt", 32'(bus.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(bus.gnt), 32'h0);
    check("async_sel", 32'(bus.sel), 32'h0);
    check("async_busy", 32'(bus.busy), 32'h0);
    model_reset();
    bus.en  = 1'b0;
    bus.req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(6, 1'b1, 4'b1111);

    // Randomized traffic with persistent requests and occasional en drops.
    r = 4'b0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      e = ($urandom_range(0, 7) != 0);
      cycle(e, r);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
